// File: rtl/ps2_keycode_rx.sv
// PS/2 scan-code set 2 receiver: frames bytes, tracks make/break/extended prefixes and
// drives the held key as a HID code. Define PS2_ARROW_KEYS_EN to map the extended arrow keys.
module ps2_keycode_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_e;
  typedef enum logic [1:0] {D_BASE, D_BRK, D_EXT, D_EXT_BRK} dec_state_e;

  logic         ps2c_s1_q, ps2c_s2_q, ps2c_prev_q, ps2d_s1_q, ps2d_s2_q;
  logic         ps2_fall, ps2_bit;

  frame_state_e fstate_q, fstate_d;
  logic [7:0]   shift_q, shift_d;
  logic [2:0]   bitcnt_q, bitcnt_d;
  logic         parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic         byte_rdy_q, byte_rdy_d;
  logic         frame_err_q, frame_err_d;

  dec_state_e   dstate_q, dstate_d;
  logic [7:0]   keycode_q, keycode_d;
  logic         key_event_q, key_event_d;
  logic         have_code, code_brk, code_ext;
  logic [7:0]   hid;

  function automatic logic [7:0] hid_of(input logic [7:0] code, input logic ext);
    logic [7:0] r;
    r = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: r = 8'h04;
        8'h23: r = 8'h07;
        8'h1B: r = 8'h16;
        8'h1D: r = 8'h1A;
        8'h29: r = 8'h2C;
        default: r = 8'h00;
      endcase
    end else begin
`ifdef PS2_ARROW_KEYS_EN
      case (code)
        8'h6B: r = 8'h50;
        8'h74: r = 8'h4F;
        8'h75: r = 8'h52;
        8'h72: r = 8'h51;
        default: r = 8'h00;
      endcase
`else
      r = 8'h00;
`endif
    end
    return r;
  endfunction

  // Synchronizer flops reset high so a released bus does not look like a falling edge.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      {ps2c_s1_q, ps2c_s2_q, ps2c_prev_q} <= 3'b111;
      {ps2d_s1_q, ps2d_s2_q}              <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge value.
      ps2c_s1_q   <= PS2_CLK;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_prev_q <= ps2c_s2_q;
      ps2d_s1_q   <= PS2_DAT;
      ps2d_s2_q   <= ps2d_s1_q;
    end
  end

  assign ps2_fall = ps2c_prev_q & ~ps2c_s2_q;
  assign ps2_bit  = ps2d_s2_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    fstate_d    = fstate_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    parity_d    = parity_q;
    tmo_d       = tmo_q;
    byte_rdy_d  = 1'b0;
    frame_err_d = 1'b0;
    if (ps2_fall) begin
      tmo_d = '0;
      case (fstate_q)
        F_IDLE: begin
          if (!ps2_bit) begin
            fstate_d = F_DATA;
            bitcnt_d = 3'd0;
          end
        end
        F_DATA: begin
          shift_d  = {ps2_bit, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) fstate_d = F_PARITY;
        end
        F_PARITY: begin
          parity_d = ps2_bit;
          fstate_d = F_STOP;
        end
        F_STOP: begin
          if (ps2_bit && (^{shift_q, parity_q})) byte_rdy_d = 1'b1;
          else                                   frame_err_d = 1'b1;
          fstate_d = F_IDLE;
        end
        default: fstate_d = F_IDLE;
      endcase
    end else if (fstate_q != F_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err_d = 1'b1;
        fstate_d    = F_IDLE;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Decoder: prefixes select the state, the code byte resolves make/break against keycode.
  always_comb begin
    dstate_d    = dstate_q;
    keycode_d   = keycode_q;
    key_event_d = 1'b0;
    have_code   = 1'b0;
    code_brk    = 1'b0;
    code_ext    = 1'b0;
    if (frame_err_q) begin
      dstate_d = D_BASE;
    end else if (byte_rdy_q) begin
      dstate_d = D_BASE;
      case (dstate_q)
        D_BASE: begin
          if (shift_q == 8'hF0)      dstate_d = D_BRK;
          else if (shift_q == 8'hE0) dstate_d = D_EXT;
          else                       have_code = 1'b1;
        end
        D_BRK: begin
          have_code = 1'b1;
          code_brk  = 1'b1;
        end
        D_EXT: begin
          if (shift_q == 8'hF0) dstate_d = D_EXT_BRK;
          else begin
            have_code = 1'b1;
            code_ext  = 1'b1;
          end
        end
        default: begin
          have_code = 1'b1;
          code_brk  = 1'b1;
          code_ext  = 1'b1;
        end
      endcase
    end
    hid = hid_of(shift_q, code_ext);
    if (have_code && hid != 8'h00) begin
      if (!code_brk && hid != keycode_q) begin
        keycode_d   = hid;
        key_event_d = 1'b1;
      end else if (code_brk && hid == keycode_q) begin
        keycode_d   = 8'h00;
        key_event_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fstate_q    <= F_IDLE;
      shift_q     <= 8'h00;
      bitcnt_q    <= 3'd0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
      dstate_q    <= D_BASE;
      keycode_q   <= 8'h00;
      key_event_q <= 1'b0;
    end else begin
      fstate_q    <= fstate_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      byte_rdy_q  <= byte_rdy_d;
      frame_err_q <= frame_err_d;
      dstate_q    <= dstate_d;
      keycode_q   <= keycode_d;
      key_event_q <= key_event_d;
    end
  end

  assign keycode   = keycode_q;
  assign key_event = key_event_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx: a table-driven key model queues expected
// key/error events, and a monitor compares them against the DUT pulses.
module tb_ps2_keycode_rx;

  localparam int TMO  = 200;
  localparam int HALF = 6;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] keycode;
  logic       key_event, frame_err;

  always #5 Clk = ~Clk;

  ps2_keycode_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .keycode(keycode), .key_event(key_event), .frame_err(frame_err)
  );

  typedef struct {
    bit         is_err;
    bit         is_tmo;
    logic [7:0] code;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0, ev_count = 0;
  int unsigned cyc = 0, last_edge = 0;

  logic [7:0] base_map[logic [7:0]];
  logic [7:0] ext_map[logic [7:0]];
  logic [7:0] m_key = 8'h00;
  bit         m_brk = 1'b0, m_ext = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: prefix flags plus table lookup.
  task automatic push_key(input logic [7:0] k);
    exp_t e;
    e.is_err = 1'b0; e.is_tmo = 1'b0; e.code = k;
    exp_q.push_back(e);
  endtask

  task automatic model_err(input bit tmo);
    exp_t e;
    e.is_err = 1'b1; e.is_tmo = tmo; e.code = 8'h00;
    exp_q.push_back(e);
    m_brk = 1'b0; m_ext = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] h;
    bit         mapped;
    if (!m_brk && b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (!m_brk && !m_ext && b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      mapped = m_ext ? ext_map.exists(b) : base_map.exists(b);
      h      = mapped ? (m_ext ? ext_map[b] : base_map[b]) : 8'h00;
      if (mapped && !m_brk && h != m_key) begin
        m_key = h; push_key(h);
      end else if (mapped && m_brk && h == m_key) begin
        m_key = 8'h00; push_key(8'h00);
      end
      m_brk = 1'b0; m_ext = 1'b0;
    end
  endtask

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk); PS2_DAT = bits[i];
      repeat (HALF) @(negedge Clk);
      PS2_CLK = 1'b0; last_edge = cyc;
      repeat (HALF) @(negedge Clk);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    if (bad_par || bad_stop) model_err(1'b0);
    else                     model_byte(b);
    ps2_bits({~bad_stop, par, b, 1'b0}, 11);
    repeat (8) @(negedge Clk);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 4 * TMO) begin
      @(negedge Clk); k++;
    end
    repeat (10) @(negedge Clk);
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (Reset_n && (key_event || frame_err)) begin
      if (key_event) ev_count++;
      check("pulse_exclusive", {31'd0, key_event & frame_err}, 0);
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_pulse: got key_event=%0b frame_err=%0b keycode=0x%0h, expected none",
                 key_event, frame_err, keycode);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {31'd0, frame_err}, {31'd0, e.is_err});
        if (!e.is_err) check("event_keycode", keycode, e.code);
        if (e.is_tmo) begin
          n_cmp++;
          if (cyc - last_edge < TMO + 2 || cyc - last_edge > TMO + 4) begin
            n_bad++;
            $display("FAIL timeout_delay: got %0d cycles, expected %0d..%0d", cyc - last_edge, TMO + 2, TMO + 4);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] pool [12];
    logic [7:0] b;
    int         ev0;
    pool = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29, 8'h6B, 8'h74, 8'h75, 8'h72, 8'hF0, 8'hE0, 8'h15};
    base_map[8'h1C] = 8'h04; base_map[8'h23] = 8'h07; base_map[8'h1B] = 8'h16;
    base_map[8'h1D] = 8'h1A; base_map[8'h29] = 8'h2C;
`ifdef PS2_ARROW_KEYS_EN
    ext_map[8'h6B] = 8'h50; ext_map[8'h74] = 8'h4F;
    ext_map[8'h75] = 8'h52; ext_map[8'h72] = 8'h51;
`endif

    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("reset_keycode", keycode, 8'h00);
    check("reset_key_event", {31'd0, key_event}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);

    repeat (2 * TMO) @(negedge Clk);
    check("idle_keycode", keycode, 8'h00);

    // W press and release
    ev0 = ev_count;
    send_byte(8'h1D, 0, 0);
    send_byte(8'hF0, 0, 0); send_byte(8'h1D, 0, 0);
    drain("drain_w");
    check("w_keycode", keycode, m_key);
    check("w_events", ev_count - ev0, 2);

    // typematic repeat, second key, release of the older key
    ev0 = ev_count;
    for (int i = 0; i < 4; i++) send_byte(8'h1C, 0, 0);
    send_byte(8'h23, 0, 0);
    send_byte(8'hF0, 0, 0); send_byte(8'h1C, 0, 0);
    drain("drain_repeat");
    check("repeat_keycode", keycode, 8'h07);
    check("repeat_events", ev_count - ev0, 2);

    // parity error, stop error, truncated frame, then recovery
    send_byte(8'h23, 1, 0);
    send_byte(8'h23, 0, 1);
    model_err(1'b1);
    ps2_bits(11'b000_1010_0110, 5);
    repeat (TMO + 20) @(negedge Clk);
    check("err_keycode", keycode, 8'h07);
    send_byte(8'h1B, 0, 0);
    drain("drain_err");
    check("recover_keycode", keycode, 8'h16);

    // extended arrow make/break, then a base key
    send_byte(8'hE0, 0, 0); send_byte(8'h6B, 0, 0);
    drain("drain_ext_make");
    check("ext_make_keycode", keycode, m_key);
    send_byte(8'hE0, 0, 0); send_byte(8'hF0, 0, 0); send_byte(8'h6B, 0, 0);
    drain("drain_ext_brk");
    check("ext_brk_keycode", keycode, m_key);
    send_byte(8'h1C, 0, 0);
    drain("drain_ext_after");
    check("ext_after_keycode", keycode, 8'h04);

    // randomized byte stream with occasional framing errors
    for (int i = 0; i < 150; i++) begin
      b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      case ($urandom_range(0, 15))
        0:       send_byte(b, 1, 0);
        1:       send_byte(b, 0, 1);
        default: send_byte(b, 0, 0);
      endcase
    end
    drain("drain_random");
    check("random_keycode", keycode, m_key);

    // reset in the middle of a frame while D is held
    send_byte(8'h23, 1, 0);
    send_byte(8'h23, 0, 0);
    drain("drain_pre_reset");
    check("pre_reset_keycode", keycode, 8'h07);
    ps2_bits({1'b1, 1'b1, 8'h1D, 1'b0}, 9);
    @(negedge Clk); Reset_n = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
    m_key = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
    check("mid_reset_keycode", keycode, 8'h00);
    ps2_bits(11'b000_0000_0011, 2);
    repeat (2 * TMO) @(negedge Clk);
    check("post_reset_keycode", keycode, 8'h00);
    send_byte(8'h1C, 0, 0);
    drain("drain_post_reset");
    check("post_reset_make", keycode, 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_keycode_rx.md
# ps2_keycode_rx

- Receives PS/2 keyboard frames and decodes scan-code set 2 make/break sequences.
- Drives an 8-bit USB-HID-style `keycode` that names the most recently pressed mapped key while it is held, and 0x00 when no mapped key is held.
- Sits between the board PS/2 connector and the ball/sprite motion logic, which reads `keycode` directly (0x04 A, 0x07 D, 0x16 S, 0x1A W).

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: `Clk` cycles (1 ms at 50 MHz) with no PS/2 falling edge before a partial frame is aborted.

Ports:
- `Clk`  in  1  system clock.
- `Reset_n`  in  1  synchronous active-low reset; one clock, reset synchronous and active-low.
- `PS2_CLK`  in  1  raw PS/2 clock, asynchronous to `Clk`.
- `PS2_DAT`  in  1  raw PS/2 data, asynchronous to `Clk`.
- `keycode`  out  8  currently held mapped key (HID code), 0x00 when none.
- `key_event`  out  1  one-cycle pulse whenever `keycode` changes value.
- `frame_err`  out  1  one-cycle pulse on parity error, stop-bit error or timeout.

## Operation
- Input conditioning:
  - `PS2_CLK` and `PS2_DAT` each pass through a 2-flop synchronizer.
  - A third flop on the synced clock detects a falling edge (prev=1, cur=0).
  - Data is sampled from synced `PS2_DAT` in the edge-detect cycle.
- Frame FSM:
  - IDLE: on an edge, if data=0 (start bit) go to DATA with the bit count cleared; a data=1 start bit is ignored.
  - DATA: shift 8 bits LSB first; after the 8th bit go to PARITY.
  - PARITY: latch the bit. Odd parity over data+parity is required; go to STOP.
  - STOP: the bit must be 1. If stop and parity are both good, assert an internal `byte_rdy` for 1 cycle with `rx_byte`, otherwise pulse `frame_err`. Return to IDLE.
  - The timeout counter clears on every edge and counts while the FSM is not IDLE. When it reaches TIMEOUT_CYCLES, pulse `frame_err` and go to IDLE.
- Decoder FSM (advances on `byte_rdy`), states BASE, BRK, EXT, EXT_BRK:
  - BASE: 0xF0 goes to BRK; 0xE0 goes to EXT; any other byte is a make of a base code, then return to BASE.
  - BRK: the byte is a break of a base code; go to BASE.
  - EXT: 0xF0 goes to EXT_BRK; otherwise the byte is a make of an extended code; go to BASE.
  - EXT_BRK: the byte is a break of an extended code; go to BASE.
  - A `frame_err` forces the decoder to BASE.
- Translation (unmapped codes are ignored, no output change):
  - Base codes: 0x1C→0x04 (A), 0x23→0x07 (D), 0x1B→0x16 (S), 0x1D→0x1A (W), 0x29→0x2C (space).
  - Extended codes (see Configuration): 0x6B→0x50 (left), 0x74→0x4F (right), 0x75→0x52 (up), 0x72→0x51 (down).
- Output rules:
  - Mapped make with a value different from `keycode`: load it and pulse `key_event`.
  - Make equal to the current `keycode` (typematic repeat): no change, no pulse.
  - Mapped break equal to the current `keycode`: clear to 0x00 and pulse `key_event`.
  - Break of any other key: no change.
  - Only one key is tracked; releasing the newer key while an older key is still held yields 0x00.

## Timing
- Reset values: `keycode`=0x00, `key_event`=0, `frame_err`=0, both FSMs in IDLE/BASE, counters 0, synchronizer flops reset to 1.
- Reset asserted mid-frame discards the partial frame and the prefix state.
- Latency from the stop-bit falling edge on the pin:
  - 3 `Clk` cycles to the edge-detect cycle.
  - `byte_rdy` in the following cycle.
  - `keycode`/`key_event` registered in the cycle after `byte_rdy`.
- `key_event` and `frame_err` are each exactly 1 cycle wide and never asserted together.
- A PS/2 edge in the same cycle the timeout fires takes priority: the counter clears and no error is raised.
- Minimum supported PS/2 half-period: 4 `Clk` cycles.

## Configuration
- `PS2_ARROW_KEYS_EN` defined: the extended arrow-key translations above are active.
- Undefined: the EXT and EXT_BRK paths are still tracked so prefixes are consumed correctly, but every extended code is treated as unmapped. Arrow keys never change `keycode`.

## Test plan
- Reset, then an idle bus for 2×TIMEOUT_CYCLES → `keycode`=0x00, no pulses.
- Frames 0x1D, then 0xF0, 0x1D → `keycode` becomes 0x1A with one `key_event`, then 0x00 with a second `key_event`.
- 0x1C make, 0x1C repeated ×3, 0x23 make, 0xF0 0x1C → sequence 0x04, 0x07, and `keycode` stays 0x07 after the A break; exactly 2 `key_event` pulses.
- Frame 0x23 with bad parity, then one with stop=0, then a frame truncated after 5 bits → `frame_err` ×3 (the last one TIMEOUT_CYCLES after the final edge); `keycode` unchanged; a following good 0x1B gives 0x16.
- 0xE0 0x6B, then 0xE0 0xF0 0x6B → with the macro: 0x50, then 0x00. Without the macro: stays 0x00 and a following 0x1C still gives 0x04.
- `Reset_n` low for 1 cycle mid-frame while `keycode`=0x07 → `keycode`=0x00 next cycle; the remainder of the frame yields no byte and no `frame_err`.
